// File: rtl/adder_sum_accumulator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adder_sum_accumulator_pkg                                     |
// | Brief    : State encoding, default widths and clog2 helper shared by     |
// |            the block-sum accumulator and its interface.                  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package adder_sum_accumulator_pkg;

    localparam int unsigned DEF_DATA_W = 12;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder_sum_accumulator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adder_sum_accumulator_if                                      |
// | Brief    : Sample-in / block-sum-out handshake bundle. out_avg exists    |
// |            only when ADDER_ACC_AVG_EN is defined.                        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface adder_sum_accumulator_if #(
    parameter int DATA_W = 12,
    parameter int LOG2_N = 3,
    parameter int ACC_W  = DATA_W + LOG2_N
);
    logic              clear;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ACC_W-1:0]  out_sum;
    logic              out_valid;
    logic              out_ready;
    logic [LOG2_N:0]   out_count;
`ifdef ADDER_ACC_AVG_EN
    logic [DATA_W-1:0] out_avg;

    modport master (
        output clear, in_data, in_valid, out_ready,
        input  in_ready, out_sum, out_valid, out_count, out_avg
    );
    modport slave (
        input  clear, in_data, in_valid, out_ready,
        output in_ready, out_sum, out_valid, out_count, out_avg
    );
`else
    modport master (
        output clear, in_data, in_valid, out_ready,
        input  in_ready, out_sum, out_valid, out_count
    );
    modport slave (
        input  clear, in_data, in_valid, out_ready,
        output in_ready, out_sum, out_valid, out_count
    );
`endif
endinterface
`default_nettype wire

// File: rtl/adder_sum_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : adder_sum_accumulator                                         |
// | Brief    : Sums blocks of N adder results and hands each block total     |
// |            downstream. Optional macro ADDER_ACC_AVG_EN adds out_avg.     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module adder_sum_accumulator
    import adder_sum_accumulator_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N      = 8,
    parameter int LOG2_N = 3,
    parameter int ACC_W  = DATA_W + LOG2_N
) (
    input  wire logic                clk,
    input  wire logic                resetn,
    adder_sum_accumulator_if.slave   bus
);

    localparam logic [LOG2_N:0] c_last_idx = (LOG2_N + 1)'(N - 1);
    localparam logic [LOG2_N:0] c_one      = (LOG2_N + 1)'(1);

    generate
        if (LOG2_N != int'(clog2(N))) begin : g_param_check
            $error("LOG2_N does not match clog2(N)");
        end
    endgenerate

    acc_state_e        r_state;
    acc_state_e        w_state_next;
    logic [ACC_W-1:0]  r_acc;
    logic [ACC_W-1:0]  w_acc_next;
    logic [ACC_W-1:0]  w_sum_in;
    logic [LOG2_N:0]   r_count;
    logic [LOG2_N:0]   w_count_next;
    logic [ACC_W-1:0]  r_sum;
    logic [ACC_W-1:0]  w_sum_next;
    logic              r_valid;
    logic              w_valid_next;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_count <= '0;
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_count <= w_count_next;
            r_sum   <= w_sum_next;
            r_valid <= w_valid_next;
        end
    end

    // in_data only reaches state through the accepted-sample path below
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_count_next = r_count;
        w_sum_next   = r_sum;
        w_valid_next = r_valid;
        w_sum_in     = r_acc + ACC_W'(bus.in_data);
        case (r_state)
            ACCUM: begin
                if (bus.clear) begin
                    w_acc_next   = '0;
                    w_count_next = '0;
                end else if (bus.in_valid) begin
                    if (r_count == c_last_idx) begin
                        w_sum_next   = w_sum_in;
                        w_valid_next = 1'b1;
                        w_acc_next   = '0;
                        w_count_next = '0;
                        w_state_next = HOLD;
                    end else begin
                        w_acc_next   = w_sum_in;
                        w_count_next = r_count + c_one;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_valid_next = 1'b0;
                    w_state_next = ACCUM;
                end
            end
        endcase
    end

    assign bus.in_ready  = (r_state == ACCUM);
    assign bus.out_sum   = r_sum;
    assign bus.out_valid = r_valid;
    assign bus.out_count = r_count;

`ifdef ADDER_ACC_AVG_EN
    logic [DATA_W-1:0] r_avg;

    // Top DATA_W bits of the block sum are the truncating average
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_avg <= '0;
        end else begin
            r_avg <= w_sum_next[ACC_W-1 -: DATA_W];
        end
    end

    assign bus.out_avg = r_avg;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_sum_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_adder_sum_accumulator                                      |
// | Brief    : Scoreboard bench for adder_sum_accumulator with a queue-based |
// |            block model; covers ADDER_ACC_AVG_EN when defined.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_adder_sum_accumulator;

    localparam int DATA_W = 12;
    localparam int N      = 8;
    localparam int LOG2_N = 3;
    localparam int ACC_W  = DATA_W + LOG2_N;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    adder_sum_accumulator_if #(.DATA_W(DATA_W), .LOG2_N(LOG2_N), .ACC_W(ACC_W)) bus ();

    adder_sum_accumulator #(
        .DATA_W (DATA_W),
        .N      (N),
        .LOG2_N (LOG2_N),
        .ACC_W  (ACC_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    // Reference model: a block is just a list of accepted samples
    int unsigned      partial[$];
    longint unsigned  exp_q[$];
    longint unsigned  last_sum;
    bit               pending;
    int               accepted;
    int               errors;
    int               checks;
    bit               mon_en;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!resetn) begin
            partial.delete();
            exp_q.delete();
            pending  = 1'b0;
            last_sum = 0;
        end else if (pending) begin
            if (bus.out_ready) pending = 1'b0;
        end else if (bus.clear) begin
            partial.delete();
        end else if (bus.in_valid) begin
            partial.push_back(int'(bus.in_data));
            accepted++;
            if (partial.size() == N) begin
                longint unsigned s;
                s = 0;
                foreach (partial[k]) s += partial[k];
                exp_q.push_back(s);
                last_sum = s;
                partial.delete();
                pending = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", bus.in_ready, !pending);
            check("out_valid", bus.out_valid, pending);
            check("out_count", bus.out_count, partial.size());
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    check("out_sum", bus.out_sum, exp_q[0]);
`ifdef ADDER_ACC_AVG_EN
                    check("out_avg", bus.out_avg, exp_q[0] >> LOG2_N);
`endif
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end else begin
                check("out_sum_kept", bus.out_sum, last_sum);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (n) cycle();
    endtask

    task automatic send(input logic [DATA_W-1:0] val, input int n, input logic rdy);
        bus.out_ready = rdy;
        bus.in_data   = val;
        for (int i = 0; i < n; i++) begin
            int target;
            int budget;
            target = accepted + 1;
            budget = 20;
            bus.in_valid = 1'b1;
            while (accepted < target && budget > 0) begin
                cycle();
                budget--;
            end
            if (accepted < target) check("accept_timeout", accepted, target);
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        accepted = 0;
        mon_en = 1'b0;
        bus.clear = 1'b0;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        resetn = 1'b0;
        cycle();
        mon_en = 1'b1;
        cycle();
        resetn = 1'b1;

        send(12'd1, 8, 1'b1);
        idle(2);
        send(12'hFFF, 8, 1'b1);
        idle(2);

        send(12'd5, 8, 1'b0);
        repeat (5) cycle();
        bus.out_ready = 1'b1;
        cycle();
        cycle();

        send(12'd100, 3, 1'b1);
        bus.clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 12'd7;
        cycle();
        bus.clear = 1'b0;
        send(12'd2, 8, 1'b1);
        idle(2);

        send(12'd9, 8, 1'b0);
        bus.clear = 1'b1;
        cycle();
        cycle();
        bus.clear = 1'b0;
        bus.out_ready = 1'b1;
        cycle();
        idle(1);

        send(12'd4, 5, 1'b1);
        resetn = 1'b0;
        cycle();
        resetn = 1'b1;
        send(12'd3, 8, 1'b1);
        idle(2);

        repeat (400) begin
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_data   = DATA_W'($urandom);
            bus.clear     = ($urandom_range(0, 19) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            resetn        = !($urandom_range(0, 99) == 0);
            cycle();
        end
        resetn = 1'b1;
        bus.clear = 1'b0;
        idle(3);
        check("drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
